// File: rtl/sram_pkg.sv
// Shared definitions for the single-port SRAM arbiter.
// Holds the priority-state encoding and the default parameter values.
package sram_pkg;

    // The requester that wins when both are valid.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

    localparam int DEPTH_DEFAULT     = 8;
    localparam int WIDTH_DEFAULT     = 4;
    localparam int MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/sram_sp.sv
// Single-port synchronous SRAM.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset (read-valid flag only)
//   we     - write enable, writes wdata to addr at the rising edge
//   re     - read enable, captures mem[addr] at the rising edge
//   addr   - word address
//   wdata  - write data
//   rdata  - read data, driven the cycle after a read, high-impedance otherwise
module sram_sp
    import sram_pkg::*;
#(
    parameter int depth = DEPTH_DEFAULT,
    parameter int width = WIDTH_DEFAULT,
    parameter int aw    = $clog2(DEPTH_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [aw-1:0]    addr,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [depth];
    logic [width-1:0] q;
    logic             q_vld;

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            q <= mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld <= 1'b0;
        end else begin
            q_vld <= re;
        end
    end

    assign rdata = q_vld ? q : {width{1'bz}};

endmodule

// File: rtl/sram_sp_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM.
// One operation per cycle; when both requesters are valid the priority
// holder wins, for at most max_burst consecutive grants before priority
// passes to the waiting requester.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata - request from requester N (N = 0, 1)
//   reqN_ready               - combinational grant to requester N
//   rspN_valid/rdata         - one-cycle read response, data zero when idle
module sram_sp_arbiter
    import sram_pkg::*;
#(
    parameter int depth     = DEPTH_DEFAULT,
    parameter int width     = WIDTH_DEFAULT,
    parameter int max_burst = MAX_BURST_DEFAULT,
    localparam int aw       = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req0_we,
    input  logic [aw-1:0]    req0_addr,
    input  logic [width-1:0] req0_wdata,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_we,
    input  logic [aw-1:0]    req1_addr,
    input  logic [width-1:0] req1_wdata,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic [width-1:0] rsp0_rdata,
    output logic             rsp1_valid,
    output logic [width-1:0] rsp1_rdata
);

    localparam logic [aw:0] depth_lim = (aw + 1)'(depth);
    localparam logic [3:0]  burst_lim = 4'(max_burst);

    pri_t             pri_q;
    pri_t             pri_d;
    logic [3:0]       burst_q;
    logic [3:0]       burst_d;
    logic             gnt0;
    logic             gnt1;
    logic             gnt_any;
    logic             gnt_we;
    logic [aw-1:0]    gnt_addr;
    logic [width-1:0] gnt_wdata;
    logic             addr_ok;
    logic             sram_we;
    logic             sram_re;
    logic [width-1:0] sram_rdata;
    logic             rsp_vld_p1;
    logic             rsp_sel_p1;
    logic             rsp_ok_p1;
    logic [width-1:0] rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q   <= PRI0;
            burst_q <= '0;
        end else begin
            pri_q   <= pri_d;
            burst_q <= burst_d;
        end
    end

    // A lone requester takes priority; a contested grant advances the
    // burst count and hands priority over when it reaches the limit.
    always_comb begin
        pri_d   = pri_q;
        burst_d = burst_q;
        if (gnt_any) begin
            if (!(req0_valid && req1_valid)) begin
                pri_d   = gnt1 ? PRI1 : PRI0;
                burst_d = '0;
            end else if (burst_q + 4'd1 == burst_lim) begin
                pri_d   = (pri_q == PRI0) ? PRI1 : PRI0;
                burst_d = '0;
            end else begin
                burst_d = burst_q + 4'd1;
            end
        end
    end

    // Grants are held low during reset so nothing is accepted then.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            gnt0 = req0_valid && (!req1_valid || pri_q == PRI0);
            gnt1 = req1_valid && (!req0_valid || pri_q == PRI1);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign gnt_any    = gnt0 || gnt1;
    assign gnt_we     = gnt1 ? req1_we    : req0_we;
    assign gnt_addr   = gnt1 ? req1_addr  : req0_addr;
    assign gnt_wdata  = gnt1 ? req1_wdata : req0_wdata;
    assign addr_ok    = {1'b0, gnt_addr} < depth_lim;

    // Out-of-range accesses never reach the SRAM.
    assign sram_we = gnt_any && gnt_we && addr_ok;
    assign sram_re = gnt_any && !gnt_we && addr_ok;

    sram_sp #(
        .depth (depth),
        .width (width),
        .aw    (aw)
    ) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (sram_we),
        .re    (sram_re),
        .addr  (gnt_addr),
        .wdata (gnt_wdata),
        .rdata (sram_rdata)
    );

    // Stage p1: read response, one cycle after acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_p1 <= 1'b0;
        end else begin
            rsp_vld_p1 <= gnt_any && !gnt_we;
        end
    end

    always_ff @(posedge clk) begin
        rsp_sel_p1 <= gnt1;
        rsp_ok_p1  <= addr_ok;
    end

    // The SRAM's high-impedance idle value is masked off here.
    assign rsp_data   = (rsp_vld_p1 && rsp_ok_p1) ? sram_rdata : '0;
    assign rsp0_valid = rsp_vld_p1 && !rsp_sel_p1;
    assign rsp1_valid = rsp_vld_p1 && rsp_sel_p1;
    assign rsp0_rdata = rsp0_valid ? rsp_data : '0;
    assign rsp1_rdata = rsp1_valid ? rsp_data : '0;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Self-checking bench for sram_sp_arbiter (depth 6 so out-of-range
// addresses 6 and 7 are reachable with a 3-bit address).
module tb_sram_sp_arbiter;
    import sram_pkg::*;

    localparam int DEPTH = 6;
    localparam int WIDTH = 4;
    localparam int MB    = 4;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0]    req0_addr = '0;
    logic [WIDTH-1:0] req0_wdata = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0]    req1_addr = '0;
    logic [WIDTH-1:0] req1_wdata = '0;
    logic             req1_ready;
    logic             rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0] rsp0_rdata, rsp1_rdata;

    always #5 clk = ~clk;

    sram_sp_arbiter #(
        .depth     (DEPTH),
        .width     (WIDTH),
        .max_burst (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: memory image, priority holder, contested-grant streak,
    // and the response expected in the current cycle.
    int mem [DEPTH];
    int holder = 0;
    int streak = 0;
    bit pend_v [2];
    int pend_d = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL c%0d %s observed=%0h expected=%0h", cyc, tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check at the negedge, update the model
    // at the posedge. Entered and left just after a rising edge.
    task automatic cycle(input bit v0, input bit we0, input int a0, input int d0,
                         input bit v1, input bit we1, input int a1, input int d1);
        int g;
        bit we;
        int a;
        int d;
        req0_valid = v0; req0_we = we0; req0_addr = a0[AW-1:0]; req0_wdata = d0[WIDTH-1:0];
        req1_valid = v1; req1_we = we1; req1_addr = a1[AW-1:0]; req1_wdata = d1[WIDTH-1:0];
        @(negedge clk);
        if (!rst_n) begin
            pend_v[0] = 1'b0;
            pend_v[1] = 1'b0;
            g = -1;
        end else if (v0 && v1) g = holder;
        else if (v0) g = 0;
        else if (v1) g = 1;
        else g = -1;
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(pend_v[0]));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(pend_v[1]));
        chk("rsp0_rdata", 32'(rsp0_rdata), pend_v[0] ? pend_d : 0);
        chk("rsp1_rdata", 32'(rsp1_rdata), pend_v[1] ? pend_d : 0);
        @(posedge clk);
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        if (g >= 0) begin
            we = (g == 1) ? we1 : we0;
            a  = ((g == 1) ? a1 : a0) & 7;
            d  = ((g == 1) ? d1 : d0) & 15;
            if (!we) begin
                pend_v[g] = 1'b1;
                pend_d = (a < DEPTH) ? mem[a] : 0;
            end else if (a < DEPTH) begin
                mem[a] = d;
            end
            if (!(v0 && v1)) begin
                holder = g;
                streak = 0;
            end else begin
                streak++;
                if (streak == MB) begin
                    holder = 1 - g;
                    streak = 0;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    // Hold reset for n cycles while throwing random requests at the DUT.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        holder = 0;
        streak = 0;
        for (int i = 0; i < n; i++)
            cycle(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 15),
                  1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 15));
        rst_n = 1'b1;
    endtask

    initial begin
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 0;
        @(posedge clk);
        #1;

        // Reset state, with both requesters trying to get in
        do_reset(3);

        // Fill every word so all later reads have a known value
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 1'b1, i, (i * 5 + 3) & 15, 1'b0, 1'b0, 0, 0);

        // Write from req0, read-after-write from req1 on the next cycle
        cycle(1'b1, 1'b1, 3, 4'hA, 1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 3, 0);
        idle();

        // Continuous contention from reset: bursts of four alternate
        do_reset(1);
        for (int i = 0; i < 18; i++)
            cycle(1'b1, 1'b0, i % DEPTH, 0, 1'b1, 1'b0, (i + 2) % DEPTH, 0);
        idle();

        // req1 alone for six cycles keeps priority through a full burst
        do_reset(1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, i, 0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, i % DEPTH, 0, 1'b1, 1'b0, 5 - (i % DEPTH), 0);
        idle();

        // Reset right after an accepted read discards its response
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1, 0);
        cycle(1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 0, 0);
        do_reset(2);
        cycle(1'b1, 1'b0, 3, 0, 1'b1, 1'b0, 4, 0);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
        idle();

        // Out-of-range write is dropped, out-of-range read returns zero
        cycle(1'b1, 1'b1, 6, 4'hF, 1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 7, 0);
        cycle(1'b1, 1'b0, 6, 0, 1'b0, 1'b0, 0, 0);
        idle();

        // Idle cycles with junk on the address and data lines
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, $urandom_range(0, 7), $urandom_range(0, 15),
                  1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 15));

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 15),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 15));
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
